// File: rtl/liteic_slave_node_write.sv
// Slave-side write node: arbitrates master write requests by QoS (round-robin on ties),
// forwards one AW+W to the AXI-Lite slave at a time and routes B back to the winner.
module liteic_slave_node_write #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int WDATA_WIDTH = 36,
  parameter int BRESP_WIDTH = 2,
  parameter int QOS_WIDTH   = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_MASTERS-1:0]             cbar_aw_val_i,
  output logic [NUM_MASTERS-1:0]             cbar_aw_rdy_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  cbar_aw_data_i,
  input  logic [NUM_MASTERS*QOS_WIDTH-1:0]   cbar_awqos_i,
  input  logic [NUM_MASTERS-1:0]             cbar_w_val_i,
  output logic [NUM_MASTERS-1:0]             cbar_w_rdy_o,
  input  logic [NUM_MASTERS*WDATA_WIDTH-1:0] cbar_w_data_i,
  output logic [NUM_MASTERS-1:0]             cbar_b_val_o,
  input  logic [NUM_MASTERS-1:0]             cbar_b_rdy_i,
  output logic [BRESP_WIDTH-1:0]             cbar_b_data_o,
  output logic [ADDR_WIDTH-1:0]              slv_aw_addr_o,
  output logic                               slv_aw_valid_o,
  input  logic                               slv_aw_ready_i,
  output logic [WDATA_WIDTH-5:0]             slv_w_data_o,
  output logic [3:0]                         slv_w_strb_o,
  output logic                               slv_w_valid_o,
  input  logic                               slv_w_ready_i,
  input  logic [BRESP_WIDTH-1:0]             slv_b_resp_i,
  input  logic                               slv_b_valid_i,
  output logic                               slv_b_ready_o
);
  // state | meaning
  // IDLE  | no grant held; arbitrate among requesting masters
  // XFER  | forwarding AW and W of the granted master, each exactly once
  // RESP  | passing the slave B response back to the granted master

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          gnt, rr_ptr, sel, sel_inc;
  logic                   aw_done, w_done;
  logic [NUM_MASTERS-1:0] req;
  logic                   any_req, aw_hs, w_hs, b_hs;
  logic [QOS_WIDTH-1:0]   best_qos;
  logic [WDATA_WIDTH-1:0] w_sel;

  logic [ADDR_WIDTH-1:0]  aw_addr [NUM_MASTERS];
  logic [WDATA_WIDTH-1:0] w_pay   [NUM_MASTERS];
  logic [QOS_WIDTH-1:0]   qos     [NUM_MASTERS];

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
    assign aw_addr[m] = cbar_aw_data_i[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_pay[m]   = cbar_w_data_i[m*WDATA_WIDTH +: WDATA_WIDTH];
    assign qos[m]     = cbar_awqos_i[m*QOS_WIDTH +: QOS_WIDTH];
  end

  assign req     = cbar_aw_val_i | cbar_w_val_i;
  assign any_req = |req;

  // Highest QoS wins; among equals, first requester scanning upward from rr_ptr.
  always_comb begin : arbitrate
    logic [GW:0]   idx_w;
    logic [GW-1:0] idx;
    logic          found;
    best_qos = '0;
    sel      = '0;
    found    = 1'b0;
    idx_w    = '0;
    idx      = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (req[m] && (qos[m] > best_qos)) best_qos = qos[m];
    end
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx_w = {1'b0, rr_ptr} + (GW+1)'(k);
      if (idx_w >= (GW+1)'(NUM_MASTERS)) idx_w = idx_w - (GW+1)'(NUM_MASTERS);
      idx = idx_w[GW-1:0];
      if (!found && req[idx] && (qos[idx] == best_qos)) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign sel_inc = (sel == GW'(NUM_MASTERS-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      gnt     <= '0;
      rr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          gnt     <= sel;
          rr_ptr  <= sel_inc;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        XFER: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = XFER;
      XFER:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cbar_aw_rdy_o  = '0;
    cbar_w_rdy_o   = '0;
    cbar_b_val_o   = '0;
    slv_aw_valid_o = 1'b0;
    slv_w_valid_o  = 1'b0;
    slv_b_ready_o  = 1'b0;
    case (state)
      XFER: begin
        slv_aw_valid_o     = cbar_aw_val_i[gnt] & ~aw_done;
        slv_w_valid_o      = cbar_w_val_i[gnt] & ~w_done;
        cbar_aw_rdy_o[gnt] = slv_aw_ready_i & ~aw_done;
        cbar_w_rdy_o[gnt]  = slv_w_ready_i & ~w_done;
      end
      RESP: begin
        slv_b_ready_o     = cbar_b_rdy_i[gnt];
        cbar_b_val_o[gnt] = slv_b_valid_i;
      end
      default: ;
    endcase
  end

  assign aw_hs = slv_aw_valid_o & slv_aw_ready_i;
  assign w_hs  = slv_w_valid_o & slv_w_ready_i;
  assign b_hs  = slv_b_valid_i & slv_b_ready_o;

  assign w_sel         = w_pay[gnt];
  assign slv_aw_addr_o = aw_addr[gnt];
  assign slv_w_data_o  = w_sel[WDATA_WIDTH-5:0];
  assign slv_w_strb_o  = w_sel[WDATA_WIDTH-1 -: 4];
  assign cbar_b_data_o = slv_b_resp_i;

endmodule

// File: tb/tb_liteic_slave_node_write.sv
// Bench for liteic_slave_node_write: directed scenarios plus random batches, with a
// QoS/round-robin reference model feeding queues that a negedge monitor drains.
module tb_liteic_slave_node_write;
  localparam int N = 4, AW = 32, WW = 36, BW = 2, QW = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0]    cbar_aw_val_i, cbar_aw_rdy_o, cbar_w_val_i, cbar_w_rdy_o;
  logic [N-1:0]    cbar_b_val_o, cbar_b_rdy_i;
  logic [N*AW-1:0] cbar_aw_data_i;
  logic [N*QW-1:0] cbar_awqos_i;
  logic [N*WW-1:0] cbar_w_data_i;
  logic [BW-1:0]   cbar_b_data_o, slv_b_resp_i;
  logic [AW-1:0]   slv_aw_addr_o;
  logic [WW-5:0]   slv_w_data_o;
  logic [3:0]      slv_w_strb_o;
  logic slv_aw_valid_o, slv_aw_ready_i, slv_w_valid_o, slv_w_ready_i;
  logic slv_b_valid_i, slv_b_ready_o;

  liteic_slave_node_write #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW),
                            .BRESP_WIDTH(BW), .QOS_WIDTH(QW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cbar_aw_val_i(cbar_aw_val_i), .cbar_aw_rdy_o(cbar_aw_rdy_o),
    .cbar_aw_data_i(cbar_aw_data_i), .cbar_awqos_i(cbar_awqos_i),
    .cbar_w_val_i(cbar_w_val_i), .cbar_w_rdy_o(cbar_w_rdy_o), .cbar_w_data_i(cbar_w_data_i),
    .cbar_b_val_o(cbar_b_val_o), .cbar_b_rdy_i(cbar_b_rdy_i), .cbar_b_data_o(cbar_b_data_o),
    .slv_aw_addr_o(slv_aw_addr_o), .slv_aw_valid_o(slv_aw_valid_o), .slv_aw_ready_i(slv_aw_ready_i),
    .slv_w_data_o(slv_w_data_o), .slv_w_strb_o(slv_w_strb_o), .slv_w_valid_o(slv_w_valid_o),
    .slv_w_ready_i(slv_w_ready_i), .slv_b_resp_i(slv_b_resp_i), .slv_b_valid_i(slv_b_valid_i),
    .slv_b_ready_o(slv_b_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;

  logic [AW-1:0] m_addr  [N];
  logic [WW-1:0] m_wdata [N];
  logic [QW-1:0] m_qos   [N];
  int  aw_dly [N], w_dly [N], b_hold [N];
  bit  aw_pend [N], w_pend [N], m_busy [N];
  bit  slv_rand = 0, b_rand = 0;
  int  w_hold = 0, force_resp = -1;
  bit  s_aw_got = 0, s_w_got = 0, s_b_act = 0;
  logic [BW-1:0] s_resp = '0;

  bit  smp_aw_hs [N], smp_w_hs [N], smp_b_hs [N], smp_bval [N];
  bit  smp_slv_aw_hs = 0, smp_slv_w_hs = 0, smp_slv_b_hs = 0;

  logic [AW-1:0] exp_aw [$];
  logic [WW-1:0] exp_w [$];
  int            exp_b [$];
  logic [BW-1:0] exp_resp [$];
  int            grant_log [$];
  int model_rr = 0;
  int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, w_rdy_cnt = 0, bwait_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int gl(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  task automatic flush();
    exp_aw.delete(); exp_w.delete(); exp_b.delete(); exp_resp.delete();
    for (int m = 0; m < N; m++) begin
      aw_pend[m] = 0; w_pend[m] = 0; m_busy[m] = 0;
      aw_dly[m] = 0; w_dly[m] = 0; b_hold[m] = 0;
      smp_aw_hs[m] = 0; smp_w_hs[m] = 0; smp_b_hs[m] = 0; smp_bval[m] = 0;
    end
    s_aw_got = 0; s_w_got = 0; s_b_act = 0; w_hold = 0; model_rr = 0;
    cbar_aw_val_i = '0; cbar_w_val_i = '0; slv_b_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    flush();
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_aw_valid"}, slv_aw_valid_o, 0);
    check({pfx, "_w_valid"},  slv_w_valid_o, 0);
    check({pfx, "_b_ready"},  slv_b_ready_o, 0);
    check({pfx, "_aw_rdy"},   cbar_aw_rdy_o, 0);
    check({pfx, "_w_rdy"},    cbar_w_rdy_o, 0);
    check({pfx, "_b_val"},    cbar_b_val_o, 0);
  endtask

  // Reference: pending requests are served highest QoS first; ties go to the
  // nearest master at or after the round-robin pointer, which then moves past it.
  task automatic start_batch(input logic [N-1:0] mask);
    bit pend [N];
    int win, key, best_key;
    for (int m = 0; m < N; m++) pend[m] = mask[m];
    repeat ($countones(mask)) begin
      win = -1; best_key = 1 << 30;
      for (int c = 0; c < N; c++) begin
        key = (16 - int'(m_qos[c])) * N + ((c - model_rr + N) % N);
        if (pend[c] && key < best_key) begin best_key = key; win = c; end
      end
      pend[win] = 0;
      model_rr = (win + 1) % N;
      exp_aw.push_back(m_addr[win]);
      exp_w.push_back(m_wdata[win]);
      exp_b.push_back(win);
    end
    for (int m = 0; m < N; m++)
      if (mask[m]) begin aw_pend[m] = 1; w_pend[m] = 1; m_busy[m] = 1; end
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    bit busy;
    do begin
      @(negedge clk_i); #2;
      cyc++;
      busy = (exp_b.size() != 0) || s_b_act;
      for (int m = 0; m < N; m++) busy |= m_busy[m] | aw_pend[m] | w_pend[m];
    end while (busy && cyc < 500);
    check({name, "_timeout"}, busy, 0);
    if (busy) do_reset();
  endtask

  task automatic clear_counts();
    aw_hs_cnt = 0; w_hs_cnt = 0; b_hs_cnt = 0; w_rdy_cnt = 0; bwait_cnt = 0;
    grant_log.delete();
  endtask

  // Master and slave behaviour, applied just after each rising edge.
  initial forever begin
    @(posedge clk_i); #1;
    for (int m = 0; m < N; m++) begin
      if (smp_aw_hs[m]) aw_pend[m] = 0;
      if (smp_w_hs[m])  w_pend[m]  = 0;
      if (smp_b_hs[m])  m_busy[m]  = 0;
      if (smp_bval[m] && b_hold[m] > 0) b_hold[m]--;
      cbar_aw_val_i[m] = aw_pend[m] && (aw_dly[m] == 0);
      cbar_w_val_i[m]  = w_pend[m] && (w_dly[m] == 0);
      if (aw_pend[m] && aw_dly[m] > 0) aw_dly[m]--;
      if (w_pend[m] && w_dly[m] > 0) w_dly[m]--;
      cbar_aw_data_i[m*AW +: AW] = m_addr[m];
      cbar_w_data_i[m*WW +: WW]  = m_wdata[m];
      cbar_awqos_i[m*QW +: QW]   = m_qos[m];
      cbar_b_rdy_i[m] = (b_hold[m] == 0) && (!b_rand || $urandom_range(0, 1) == 1);
    end
    if (smp_slv_aw_hs) s_aw_got = 1;
    if (smp_slv_w_hs)  s_w_got  = 1;
    if (s_b_act && smp_slv_b_hs) begin
      s_b_act = 0; s_aw_got = 0; s_w_got = 0;
    end else if (!s_b_act && s_aw_got && s_w_got) begin
      s_b_act = 1;
      s_resp  = (force_resp >= 0) ? BW'(force_resp) : BW'($urandom_range(0, 3));
      exp_resp.push_back(s_resp);
    end
    slv_b_valid_i  = s_b_act;
    slv_b_resp_i   = s_resp;
    slv_aw_ready_i = !slv_rand || ($urandom_range(0, 2) != 0);
    if (w_hold > 0) begin slv_w_ready_i = 1'b0; w_hold--; end
    else slv_w_ready_i = !slv_rand || ($urandom_range(0, 2) != 0);
  end

  // Monitor: samples on the falling edge and drains the expectation queues.
  initial forever begin
    int g;
    @(negedge clk_i);
    if (rst_i) begin
      for (int m = 0; m < N; m++) begin
        smp_aw_hs[m] = 0; smp_w_hs[m] = 0; smp_b_hs[m] = 0; smp_bval[m] = 0;
      end
      smp_slv_aw_hs = 0; smp_slv_w_hs = 0; smp_slv_b_hs = 0;
    end else begin
      for (int m = 0; m < N; m++) begin
        smp_aw_hs[m] = cbar_aw_val_i[m] && cbar_aw_rdy_o[m];
        smp_w_hs[m]  = cbar_w_val_i[m] && cbar_w_rdy_o[m];
        smp_b_hs[m]  = cbar_b_val_o[m] && cbar_b_rdy_i[m];
        smp_bval[m]  = cbar_b_val_o[m];
      end
      smp_slv_aw_hs = slv_aw_valid_o && slv_aw_ready_i;
      smp_slv_w_hs  = slv_w_valid_o && slv_w_ready_i;
      smp_slv_b_hs  = slv_b_valid_i && slv_b_ready_o;
      if (smp_slv_aw_hs) begin
        aw_hs_cnt++;
        if (exp_aw.size() == 0) check("aw_unexpected", slv_aw_addr_o, 0);
        else check("aw_addr", slv_aw_addr_o, exp_aw.pop_front());
      end
      if (smp_slv_w_hs) begin
        w_hs_cnt++;
        if (exp_w.size() == 0) check("w_unexpected", {slv_w_strb_o, slv_w_data_o}, 0);
        else check("w_payload", {slv_w_strb_o, slv_w_data_o}, exp_w.pop_front());
      end
      if (cbar_w_rdy_o != 0) w_rdy_cnt++;
      if (slv_b_ready_o) check("resp_after_both", s_aw_got && s_w_got, 1);
      if (cbar_b_val_o != 0) begin
        if (exp_b.size() == 0) check("b_unexpected", cbar_b_val_o, 0);
        else begin
          check("b_val_route", cbar_b_val_o, 64'(1) << exp_b[0]);
          check("b_ready_route", slv_b_ready_o, cbar_b_rdy_i[exp_b[0]]);
          if (!cbar_b_rdy_i[exp_b[0]]) bwait_cnt++;
          if (smp_slv_b_hs) begin
            b_hs_cnt++;
            g = -1;
            for (int m = 0; m < N; m++) if (cbar_b_val_o[m]) g = m;
            grant_log.push_back(g);
            void'(exp_b.pop_front());
            if (exp_resp.size() == 0) check("b_resp_missing", cbar_b_data_o, 0);
            else check("b_data", cbar_b_data_o, exp_resp.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    cbar_aw_val_i = '0; cbar_w_val_i = '0; cbar_b_rdy_i = '0;
    cbar_aw_data_i = '0; cbar_w_data_i = '0; cbar_awqos_i = '0;
    slv_aw_ready_i = 0; slv_w_ready_i = 0; slv_b_valid_i = 0; slv_b_resp_i = '0;
    for (int m = 0; m < N; m++) begin
      m_addr[m] = $urandom; m_wdata[m] = {4'($urandom), $urandom}; m_qos[m] = '0;
    end

    // Reset state; data outputs follow master 0.
    do_reset();
    check_quiet("reset");
    check("reset_aw_addr", slv_aw_addr_o, m_addr[0]);
    check("reset_w_payload", {slv_w_strb_o, slv_w_data_o}, m_wdata[0]);

    // Single write from master 2.
    m_addr[2] = 32'h1000_0040; m_wdata[2] = 36'hF_DEAD_BEEF; m_qos[2] = 0;
    force_resp = 0; clear_counts();
    start_batch(4'b0100);
    @(negedge clk_i); #2;
    check("single_idle_cycle", slv_aw_valid_o, 0);
    @(negedge clk_i); #2;
    check("single_aw_valid", slv_aw_valid_o, 1);
    check("single_aw_addr", slv_aw_addr_o, 32'h1000_0040);
    check("single_w_data", slv_w_data_o, 32'hDEAD_BEEF);
    check("single_w_strb", slv_w_strb_o, 4'hF);
    wait_done("single");
    check("single_grant", gl(0), 2);

    // QoS priority from rr_ptr=0.
    do_reset(); clear_counts(); force_resp = -1;
    m_qos[0] = 2; m_qos[1] = 7; m_qos[3] = 7;
    start_batch(4'b1011);
    wait_done("qos");
    check("qos_order0", gl(0), 1);
    check("qos_order1", gl(1), 3);
    check("qos_order2", gl(2), 0);

    // Round-robin at equal QoS.
    do_reset(); clear_counts();
    for (int m = 0; m < N; m++) m_qos[m] = 0;
    start_batch(4'hF); wait_done("rr_a");
    start_batch(4'hF); wait_done("rr_b");
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), gl(i), i % N);

    // W three cycles ahead of AW, slave W ready low two cycles.
    clear_counts();
    aw_dly[1] = 3; w_hold = 2;
    start_batch(4'b0010);
    wait_done("split");
    check("split_aw_once", aw_hs_cnt, 1);
    check("split_w_once", w_hs_cnt, 1);
    check("split_w_rdy_pulse", w_rdy_cnt, 1);

    // B backpressure.
    clear_counts();
    b_hold[0] = 4; force_resp = 2;
    start_batch(4'b0001);
    wait_done("bp");
    check("bp_wait_cycles", bwait_cnt, 4);
    check("bp_handshakes", b_hs_cnt, 1);
    check("bp_idle_b_ready", slv_b_ready_o, 0);
    check("bp_idle_b_val", cbar_b_val_o, 0);
    force_resp = -1;

    // Asynchronous reset after AW, before W.
    clear_counts();
    w_dly[2] = 20;
    start_batch(4'b0100);
    for (int i = 0; i < 20 && aw_hs_cnt == 0; i++) begin @(negedge clk_i); #2; end
    check("midrst_aw_seen", aw_hs_cnt, 1);
    check("midrst_w_rdy_pre", cbar_w_rdy_o, 4'b0100);
    #1 rst_i = 1'b1;
    #1 check_quiet("midrst");
    do_reset(); clear_counts();
    for (int m = 0; m < N; m++) m_qos[m] = 0;
    start_batch(4'hF);
    wait_done("post_rst");
    check("post_rst_first_grant", gl(0), 0);

    // Random batches.
    slv_rand = 1; b_rand = 1;
    for (int t = 0; t < 30; t++) begin
      for (int m = 0; m < N; m++) begin
        m_addr[m] = $urandom; m_wdata[m] = {4'($urandom), $urandom};
        m_qos[m] = QW'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) begin aw_dly[m] = $urandom_range(0, 4); w_dly[m] = 0; end
        else begin w_dly[m] = $urandom_range(0, 4); aw_dly[m] = 0; end
      end
      start_batch(N'($urandom_range(1, (1 << N) - 1)));
      wait_done("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
